// File: rtl/logic_unit_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_arbiter_if
// Brief    : Requester, logic-unit and response buses of logic_unit_arbiter.
//            slave  = arbiter view, master = environment view.
// Revision : 1.0 - initial release
// ============================================================================
interface logic_unit_arbiter_if;
  // Requester 0
  logic       req0_valid;
  logic       req0_ready;
  logic [3:0] req0_x;
  logic [3:0] req0_y;
  logic [1:0] req0_mode;
  logic       req0_of;
  // Requester 1
  logic       req1_valid;
  logic       req1_ready;
  logic [3:0] req1_x;
  logic [3:0] req1_y;
  logic [1:0] req1_mode;
  logic       req1_of;
  // Shared logic unit
  logic [3:0] lu_x;
  logic [3:0] lu_y;
  logic [1:0] lu_mode;
  logic       lu_of;
  logic [8:0] lu_out;
  // Response
  logic       rsp_valid;
  logic       rsp_ready;
  logic [8:0] rsp_data;
  logic       rsp_id;

  modport slave (
    input  req0_valid, req0_x, req0_y, req0_mode, req0_of,
    output req0_ready,
    input  req1_valid, req1_x, req1_y, req1_mode, req1_of,
    output req1_ready,
    output lu_x, lu_y, lu_mode, lu_of,
    input  lu_out,
    output rsp_valid, rsp_data, rsp_id,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_x, req0_y, req0_mode, req0_of,
    input  req0_ready,
    output req1_valid, req1_x, req1_y, req1_mode, req1_of,
    input  req1_ready,
    input  lu_x, lu_y, lu_mode, lu_of,
    output lu_out,
    input  rsp_valid, rsp_data, rsp_id,
    output rsp_ready
  );
endinterface
`default_nettype wire

// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_arbiter
// Brief    : Two-requester scheduler for one shared combinational logic unit.
//            Accepts one operation, holds operands on the unit for
//            HOLD_CYCLES (1..15) cycles, then returns the sampled result
//            tagged with the requester ID.
//            Define LOGIC_ARB_RR_EN for round-robin arbitration; otherwise
//            requester 0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module logic_unit_arbiter #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  logic_unit_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Counter reload: the result is sampled on the cycle the counter hits 0.
  localparam logic [3:0] c_hold_load = 4'(HOLD_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_cnt;
  logic       r_id;
  logic       w_grant0;
  logic       w_grant1;
  logic       w_accept;
  logic       w_capture;
  logic       w_release;

`ifdef LOGIC_ARB_RR_EN
  // 1 = requester 1 was granted last; reset value lets requester 0 win first.
  logic r_last_grant;

  // Round-robin grant: on contention the requester not served last wins.
  always_comb begin
    w_grant0 = bus.req0_valid;
    w_grant1 = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      w_grant0 = r_last_grant;
      w_grant1 = ~r_last_grant;
    end
  end

  // Pointer moves only on an accepted handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_last_grant <= w_grant1;
    end
  end
`else
  // Fixed priority grant: requester 0 always beats requester 1.
  always_comb begin
    w_grant0 = bus.req0_valid;
    w_grant1 = bus.req1_valid & ~bus.req0_valid;
  end
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, ready outputs and datapath strobes.
  always_comb begin
    w_state_next   = r_state;
    w_accept       = 1'b0;
    w_capture      = 1'b0;
    w_release      = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    case (r_state)
      IDLE: begin
        // rst_n gating keeps both readys low while reset is held.
        bus.req0_ready = w_grant0 & rst_n;
        bus.req1_ready = w_grant1 & rst_n;
        if (w_grant0 || w_grant1) begin
          w_accept     = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (r_cnt == 4'd0) begin
          w_capture    = 1'b1;
          w_state_next = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          w_release    = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operand latch, requester ID and hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.lu_x    <= 4'd0;
      bus.lu_y    <= 4'd0;
      bus.lu_mode <= 2'd0;
      bus.lu_of   <= 1'b0;
      r_id        <= 1'b0;
      r_cnt       <= 4'd0;
    end else if (w_accept) begin
      if (w_grant0) begin
        bus.lu_x    <= bus.req0_x;
        bus.lu_y    <= bus.req0_y;
        bus.lu_mode <= bus.req0_mode;
        bus.lu_of   <= bus.req0_of;
      end else begin
        bus.lu_x    <= bus.req1_x;
        bus.lu_y    <= bus.req1_y;
        bus.lu_mode <= bus.req1_mode;
        bus.lu_of   <= bus.req1_of;
      end
      r_id  <= w_grant1;
      r_cnt <= c_hold_load;
    end else if (r_state == ISSUE && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Response register: captures the unit output verbatim and holds it
  // until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= 9'd0;
      bus.rsp_id    <= 1'b0;
    end else if (w_capture) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_data  <= bus.lu_out;
      bus.rsp_id    <= r_id;
    end else if (w_release) begin
      bus.rsp_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_unit_arbiter
// Brief    : Directed self-checking bench for logic_unit_arbiter with a
//            behavioural model of the shared logic unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_unit_arbiter;

  localparam int HOLD = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic_unit_arbiter_if bus();

  logic_unit_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Logic unit model: result bit 8 is the flag; NOT inverts both operands.
  always_comb begin
    case (bus.lu_mode)
      2'b00:   bus.lu_out = {bus.lu_of, 4'h0, bus.lu_x & bus.lu_y};
      2'b01:   bus.lu_out = {bus.lu_of, 4'h0, bus.lu_x | bus.lu_y};
      2'b10:   bus.lu_out = {bus.lu_of, 4'h0, bus.lu_x ^ bus.lu_y};
      default: bus.lu_out = {bus.lu_of, ~bus.lu_x, ~bus.lu_y};
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_x = 4'h0; bus.req0_y = 4'h0;
    bus.req0_mode  = 2'b00; bus.req0_of = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_x = 4'h0; bus.req1_y = 4'h0;
    bus.req1_mode  = 2'b00; bus.req1_of = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy0"},  bus.req0_ready, 0);
    chk({tag, "_rdy1"},  bus.req1_ready, 0);
    chk({tag, "_lux"},   bus.lu_x, 0);
    chk({tag, "_luy"},   bus.lu_y, 0);
    chk({tag, "_lumode"}, bus.lu_mode, 0);
    chk({tag, "_luof"},  bus.lu_of, 0);
    chk({tag, "_rspv"},  bus.rsp_valid, 0);
    chk({tag, "_rspd"},  bus.rsp_data, 0);
    chk({tag, "_rspid"}, bus.rsp_id, 0);
  endtask

  // One operation from an idle arbiter; returns with rsp_valid just seen
  // (and, if rsp_ready is high, after the response was taken).
  task automatic do_op(input logic who, input logic [3:0] x, input logic [3:0] y,
                       input logic [1:0] m, input logic of, input logic [8:0] exp);
    int lat;
    if (!who) begin
      bus.req0_valid = 1'b1; bus.req0_x = x; bus.req0_y = y;
      bus.req0_mode = m; bus.req0_of = of;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_x = x; bus.req1_y = y;
      bus.req1_mode = m; bus.req1_of = of;
    end
    #1;
    chk("ready_grant", who ? bus.req1_ready : bus.req0_ready, 1);
    chk("ready_other", who ? bus.req0_ready : bus.req1_ready, 0);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 32) begin
      chk("lu_x", bus.lu_x, x);
      chk("lu_y", bus.lu_y, y);
      chk("lu_mode", bus.lu_mode, m);
      chk("lu_of", bus.lu_of, of);
      chk("busy_ready", {bus.req0_ready, bus.req1_ready}, 0);
      tick();
      lat++;
    end
    chk("latency", lat, HOLD);
    chk("rsp_data", bus.rsp_data, exp);
    chk("rsp_id", bus.rsp_id, who);
    if (bus.rsp_ready) begin
      tick();
      chk("rsp_taken", bus.rsp_valid, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_id [4];
    int   nresp;
    int   last;
`ifdef LOGIC_ARB_RR_EN
    exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_id = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

    // Reset state, with a request pending to prove ready stays low.
    idle_inputs();
    bus.rsp_ready  = 1'b1;
    bus.req0_valid = 1'b1;
    repeat (2) tick();
    chk_all_zero("reset");
    bus.req0_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // AND: C & A = 8
    do_op(1'b0, 4'hC, 4'hA, 2'b00, 1'b0, 9'h008);
    // NOT with flag: {1, ~3, ~5}
    do_op(1'b1, 4'h3, 4'h5, 2'b11, 1'b1, 9'h1CA);

    // Backpressure: OR 9|6 = F, consumer stalls 5 cycles.
    bus.rsp_ready = 1'b0;
    do_op(1'b0, 4'h9, 4'h6, 2'b01, 1'b0, 9'h00F);
    bus.req1_valid = 1'b1; bus.req1_x = 4'hF; bus.req1_y = 4'h3;
    bus.req1_mode = 2'b00; bus.req1_of = 1'b0;
    repeat (5) begin
      tick();
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_data", bus.rsp_data, 9'h00F);
      chk("bp_id", bus.rsp_id, 0);
      chk("bp_ready", {bus.req0_ready, bus.req1_ready}, 0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_release", bus.rsp_valid, 0);
    chk("bp_resume_ready", bus.req1_ready, 1);
    do_op(1'b1, 4'hF, 4'h3, 2'b00, 1'b0, 9'h003);

    // Contention: fresh reset so the round-robin pointer is known.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_x = 4'hF; bus.req0_y = 4'h5; bus.req0_mode = 2'b10;
    bus.req1_valid = 1'b1; bus.req1_x = 4'hF; bus.req1_y = 4'h5; bus.req1_mode = 2'b10;
    #1;
    nresp = 0;
    last  = 0;
    for (int c = 0; c < 4 * (HOLD + 2) + 20 && nresp < 4; c++) begin
      chk("both_ready", bus.req0_ready & bus.req1_ready, 0);
      if (bus.rsp_valid) begin
        chk($sformatf("grant%0d", nresp), bus.rsp_id, exp_id[nresp]);
        chk("xor_data", bus.rsp_data, 9'h00A);
        if (nresp > 0) chk("period", c - last, HOLD + 2);
        last = c;
        nresp++;
      end
      tick();
    end
    chk("contention_count", nresp, 4);
    idle_inputs();
    tick();

    // Reset two cycles into ISSUE aborts the operation.
    bus.req0_valid = 1'b1; bus.req0_x = 4'h7; bus.req0_y = 4'hE;
    bus.req0_mode = 2'b00; bus.req0_of = 1'b1;
    #1;
    tick();
    bus.req0_valid = 1'b0;
    chk("abort_lu_loaded", bus.lu_x, 4'h7);
    tick();
    tick();
    bus.req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    tick();
    tick();
    chk("rst_hold_rspv", bus.rsp_valid, 0);
    chk("rst_hold_rdy1", bus.req1_ready, 0);
    bus.req1_valid = 1'b0;
    rst_n = 1'b1;
    repeat (HOLD + 3) begin
      tick();
      chk("no_rsp_after_abort", bus.rsp_valid, 0);
    end
    // XOR 6^3 = 5, flag set.
    do_op(1'b1, 4'h6, 4'h3, 2'b10, 1'b1, 9'h105);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
